nibble_accum: RTL

NIBBLE_ACCUM -- requirements
Module: nibble_accum

---
 rtl/nibble_accum_if.sv | 25 ++
 rtl/nibble_accum.sv | 131 +++++++++++++
 2 files changed

// File: rtl/nibble_accum_if.sv
// Operand and result handshake bundle for nibble_accum.
// The slave modport is the accumulator; the master modport is the producer/consumer side.
interface nibble_accum_if #(
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_sum;
   logic             out_ovf;
   logic [CNT_W-1:0] out_count;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_count
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_count
   );
endinterface

// File: rtl/nibble_accum.sv
// Serial nibble accumulator: one shared 4-bit adder builds an 8-bit running total
// over a group of operands, two add cycles per operand (low then high nibble).
module nibble_accum #(
   parameter int CNT_W = 4
) (
   input  logic           clock,
   input  logic           reset,
   nibble_accum_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADD_LO = 2'd1,
      ADD_HI = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       acc_q, acc_d;
   logic [3:0]       op_q, op_d;
   logic             last_q, last_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [3:0]       add_a_s;
   logic [3:0]       add_b_s;
   logic             add_cin_s;
   logic [4:0]       add_res_s;

   // Shared adder operand steering: high pass only propagates the stored carry.
   always_comb begin
      add_a_s   = acc_q[3:0];
      add_b_s   = op_q;
      add_cin_s = 1'b0;
      if (state_q == ADD_HI) begin
         add_a_s   = acc_q[7:4];
         add_b_s   = 4'd0;
         add_cin_s = carry_q;
      end else begin
         add_a_s   = acc_q[3:0];
         add_b_s   = op_q;
         add_cin_s = 1'b0;
      end
      add_res_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {4'd0, add_cin_s};
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op_d    = op_q;
      last_d  = last_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d   = bus.in_data;
               last_d = bus.in_last;
               if (count_q != {CNT_W{1'b1}}) begin
                  count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  count_d = count_q;
               end
               state_d = ADD_LO;
            end else begin
               state_d = IDLE;
            end
         end
         ADD_LO: begin
            acc_d   = {acc_q[7:4], add_res_s[3:0]};
            carry_d = add_res_s[4];
            state_d = ADD_HI;
         end
         ADD_HI: begin
            acc_d = {add_res_s[3:0], acc_q[3:0]};
            // A carry out of the high nibble means the total wrapped past 255.
            ovf_d = ovf_q | add_res_s[4];
            if (last_q) begin
               state_d = DONE;
            end else begin
               state_d = IDLE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               acc_d   = 8'd0;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               count_d = {CNT_W{1'b0}};
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= 8'd0;
         op_q    <= 4'd0;
         last_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         count_q <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         last_q  <= last_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_sum   = acc_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.out_count = count_q;

endmodule
